// File: rtl/rgb_led_arbiter.sv
// Fixed-priority owner of the shared RGB LED, with a minimum hold time before preemption.
// The owner's color is shown with an optional grant-aligned blink and global PWM dimming.
module rgb_led_arbiter #(
  parameter int CLK_FREQUENCY   = 48000000,
  parameter int N_REQ           = 4,
  parameter bit RGB_LOGIC_LEVEL = 1'b0,
  parameter int MIN_HOLD_MS     = 100,
  parameter int BLINK_PERIOD_MS = 500,
  parameter int PWM_BITS        = 8
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [3*N_REQ-1:0]    req_color,
  input  logic [N_REQ-1:0]      req_blink,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  rgb_led0_r,
  output logic                  rgb_led0_g,
  output logic                  rgb_led0_b
);

  localparam int TICK    = CLK_FREQUENCY / 1000;
  localparam int PRE_W   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int HOLD_W  = $clog2(MIN_HOLD_MS + 1);
  localparam int HALF    = BLINK_PERIOD_MS / 2;
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IDX_W   = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, HOLD, OWNED} state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    owner, owner_nx;
  logic                handover;
  logic [PRE_W-1:0]    pre_cnt;
  logic [HOLD_W-1:0]   hold_ms;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_on;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [2:0]          pads_p1;

  logic                ms_tick;
  logic                hold_done;
  logic [IDX_W-1:0]    low_idx;
  logic [2:0]          lit;
  logic                show;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign ms_tick   = (pre_cnt == PRE_W'(TICK - 1));
  assign hold_done = ms_tick && (hold_ms == HOLD_W'(MIN_HOLD_MS - 1));
  assign low_idx   = lowest_idx(req);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    handover = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = HOLD;
          owner_nx = low_idx;
          handover = 1'b1;
        end
      end
      HOLD: begin
        if (!req[owner]) begin
          if (|req) begin
            owner_nx = low_idx;
            handover = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (hold_done) begin
          state_nx = OWNED;
        end
      end
      OWNED: begin
        // Lowest active index differs from the owner only on preemption or release.
        if (|req) begin
          if (low_idx != owner) begin
            state_nx = HOLD;
            owner_nx = low_idx;
            handover = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    show = busy && (blink_on || !req_blink[owner]) && (pwm_cnt < brightness);
    lit  = {3{show}} & req_color[3*int'(owner) +: 3];
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      owner     <= '0;
      grant     <= '0;
      pre_cnt   <= '0;
      hold_ms   <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      pwm_cnt   <= '0;
      pads_p1   <= {3{~RGB_LOGIC_LEVEL}};
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      grant   <= (state_nx == IDLE) ? '0 : (N_REQ'(1) << owner_nx);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (handover || state_nx == IDLE) begin
        pre_cnt   <= '0;
        hold_ms   <= '0;
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else begin
        pre_cnt <= ms_tick ? '0 : pre_cnt + PRE_W'(1);
        if (ms_tick) begin
          if (state == HOLD) hold_ms <= hold_ms + HOLD_W'(1);
          if (blink_cnt == BLINK_W'(HALF - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end
        end
      end
      // pad stage p1: registered drive levels
      pads_p1 <= lit ^ {3{~RGB_LOGIC_LEVEL}};
    end
  end

  assign rgb_led0_r = pads_p1[2];
  assign rgb_led0_g = pads_p1[1];
  assign rgb_led0_b = pads_p1[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: directed scenarios with literal expectations plus
// random traffic compared every cycle against a cycle-count based reference model.
module tb_rgb_led_arbiter;
  localparam int N        = 4;
  localparam int HOLD_CYC = 4;
  localparam int HALF_CYC = 2;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req;
  logic [11:0] req_color;
  logic [3:0]  req_blink;
  logic [1:0]  brightness;
  logic [3:0]  grant;
  logic        busy;
  logic        rgb_led0_r, rgb_led0_g, rgb_led0_b;
  logic [2:0]  pads;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int         m_owner = -1;
  int         m_age   = 0;
  int         m_pwm   = 0;
  logic [2:0] m_pads  = 3'b111;

  assign pads = {rgb_led0_r, rgb_led0_g, rgb_led0_b};

  always #5 clk = ~clk;

  rgb_led_arbiter #(
    .CLK_FREQUENCY(1000), .N_REQ(N), .RGB_LOGIC_LEVEL(1'b0),
    .MIN_HOLD_MS(4), .BLINK_PERIOD_MS(4), .PWM_BITS(2)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .req(req), .req_color(req_color),
    .req_blink(req_blink), .brightness(brightness), .grant(grant), .busy(busy),
    .rgb_led0_r(rgb_led0_r), .rgb_led0_g(rgb_led0_g), .rgb_led0_b(rgb_led0_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: owner, cycles since grant, free-running pwm, pads one cycle behind.
  always @(posedge clk) begin
    int         low;
    logic [2:0] lit;
    bit         blink_ok, pwm_ok;
    if (sys_rst) begin
      m_owner = -1;
      m_age   = 0;
      m_pwm   = 0;
      m_pads  = 3'b111;
    end else begin
      lit = 3'b000;
      if (m_owner >= 0) begin
        blink_ok = !req_blink[m_owner] || (((m_age / HALF_CYC) % 2) == 0);
        pwm_ok   = (m_pwm < int'(brightness));
        if (blink_ok && pwm_ok) lit = req_color[3*m_owner +: 3];
      end
      m_pads = ~lit;
      low = -1;
      for (int i = N - 1; i >= 0; i--) if (req[i]) low = i;
      if (m_owner < 0) begin
        if (low >= 0) begin m_owner = low; m_age = 0; end
      end else if (!req[m_owner]) begin
        m_owner = low;
        m_age   = 0;
      end else if (m_age >= HOLD_CYC && low < m_owner) begin
        m_owner = low;
        m_age   = 0;
      end else begin
        m_age++;
      end
      m_pwm = (m_pwm + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_grant", grant, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
      check("cmp_busy", busy, (m_owner >= 0));
      check("cmp_pads", pads, m_pads);
    end
  end

  task automatic restart();
    sys_rst = 1'b1;
    req     = 4'b0000;
    tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    int glow;
    int on_cnt;
    sys_rst    = 1'b1;
    req        = 4'b1111;
    req_color  = {3'b111, 3'b010, 3'b101, 3'b111};
    req_blink  = 4'b0000;
    brightness = 2'd3;
    tick();
    chk_en = 1'b1;
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_pads", pads, 3'b111);
    sys_rst = 1'b0;
    tick();
    check("rel_grant", grant, 4'b0001);
    check("model_owner", m_owner, 0);

    // priority and hold
    restart();
    req = 4'b0100;
    tick();
    check("hold_grant0", grant, 4'b0100);
    glow = 0;
    tick();
    req = 4'b0101;
    if (!rgb_led0_g) glow++;
    for (int k = 2; k <= 4; k++) begin
      tick();
      if (!rgb_led0_g) glow++;
      check("hold_keep", grant, 4'b0100);
    end
    tick();
    check("hold_preempt", grant, 4'b0001);
    check("g_duty", glow, 3);

    // release with handover, then to idle
    restart();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick();
    tick();
    req = 4'b1000;
    tick();
    check("rel_handover", grant, 4'b1000);
    check("rel_busy", busy, 1'b1);
    req = 4'b0000;
    tick();
    check("idle_grant", grant, 4'b0000);
    check("idle_busy", busy, 1'b0);
    tick();
    check("idle_pads", pads, 3'b111);

    // lower-priority requests never preempt
    restart();
    req = 4'b0010;
    tick();
    repeat (6) tick();
    check("model_age", m_age, 6);
    req = 4'b1110;
    repeat (10) begin
      tick();
      check("no_preempt", grant, 4'b0010);
    end

    // brightness zero keeps the LED dark
    restart();
    req        = 4'b1000;
    req_blink  = 4'b1000;
    brightness = 2'd0;
    repeat (8) begin
      tick();
      check("dark_pads", pads, 3'b111);
    end

    // blink envelope, starting ON at grant
    restart();
    brightness = 2'd3;
    req        = 4'b1000;
    tick();
    on_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 2 && pads != 3'b111) on_cnt++;
      if (c % 4 == 3 || c % 4 == 0) check("blink_off", pads, 3'b111);
    end
    check("blink_on_start", (on_cnt > 0), 1'b1);

    // reset in the middle of a hold
    restart();
    req_blink = 4'b0000;
    req = 4'b0100;
    tick();
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    check("midrst_grant", grant, 4'b0000);
    sys_rst = 1'b0;
    req = 4'b0110;
    tick();
    check("midrst_regrant", grant, 4'b0010);
    req = 4'b0111;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("midrst_hold", grant, 4'b0010);
    end
    tick();
    check("midrst_preempt", grant, 4'b0001);

    // random traffic against the model
    repeat (2000) begin
      tick();
      if ($urandom_range(0, 5) == 0) req = req ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) req_color = 12'($urandom);
      if ($urandom_range(0, 15) == 0) req_blink = 4'($urandom);
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
      sys_rst = ($urandom_range(0, 199) == 0);
    end
    sys_rst = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the board's single RGB LED between up to N_REQ status requesters, such as the reset/boot indicator, the UART activity monitor and the application heartbeat. Arbitration is fixed-priority with a minimum ownership hold, so a brief high-priority event cannot make the LED flicker. The owner's color is driven with optional blink and global PWM dimming. The block sits between the requester logic and the rgb_led0_r/g/b pads, in the clk48 domain, and is reset by the debounced sys_rst from sys_boot_rst.

## Interface
Parameters:
- CLK_FREQUENCY, 48000000: clk frequency in Hz; one ms tick = CLK_FREQUENCY/1000 cycles (integer).
- N_REQ, 4: number of requesters (2..8); index 0 has highest priority.
- RGB_LOGIC_LEVEL, 0: pad level that lights an LED channel.
- MIN_HOLD_MS, 100: minimum ms an owner keeps the LED before it can be preempted (≥1).
- BLINK_PERIOD_MS, 500: full blink period in ms (even, ≥2).
- PWM_BITS, 8: width of the brightness and PWM counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (clk48).
- sys_rst  in  1  synchronous active-high reset.
- req  in  N_REQ  request level per requester; held high while the requester wants the LED.
- req_color  in  3*N_REQ  per-requester {r,g,b}; requester i uses bits [3i+2:3i], with r at 3i+2.
- req_blink  in  N_REQ  per-requester blink enable.
- brightness  in  PWM_BITS  global duty; 0 means always off.
- grant  out  N_REQ  one-hot current owner, or all zero when idle.
- busy  out  1  high when any requester owns the LED.
- rgb_led0_r, rgb_led0_g, rgb_led0_b  out  1 each  LED pad drives.

## Operation
- States:
  - IDLE: no owner.
  - HOLD: owner assigned, hold timer running, no preemption.
  - OWNED: hold expired, preemptable.
- IDLE: if any req is high, grant the lowest-index active requester and go to HOLD.
- HOLD: if the owner drops req, hand over immediately to the lowest-index other active requester, entering HOLD with the timer restarted; if none is active, go to IDLE. Higher-priority requests are ignored. When the hold timer reaches MIN_HOLD_MS ms, go to OWNED.
- OWNED:
  - If a lower-index req is high, hand over to the lowest such index and enter HOLD.
  - Else, if the owner dropped req, apply the same release/handover rule as HOLD.
  - Equal- or higher-index requesters never preempt.
- Hold timer: a ms prescaler plus an ms counter. Both clear on every grant or handover, so the hold lasts exactly MIN_HOLD_MS*CLK_FREQUENCY/1000 cycles.
- Blink: the phase starts ON at every grant or handover and toggles every BLINK_PERIOD_MS/2 ms, counted from the same grant-aligned tick. If req_blink of the owner is low, the phase is forced ON.
- PWM: pwm_cnt is free-running, PWM_BITS wide, wraps at 2^PWM_BITS−1 → 0, and is not reset by grants. pwm_on = (pwm_cnt < brightness), unsigned.
- Channel lit = busy & blink_on & pwm_on & owner color bit. The color is sampled live from the owner's req_color every cycle.
- Lit channel drives RGB_LOGIC_LEVEL; unlit channel drives ~RGB_LOGIC_LEVEL.
- Simultaneous events:
  - Owner drops in the same cycle a higher-priority request rises: the new owner is the lowest active index, with no idle cycle.
  - Handover to a new owner always restarts hold and blink.
- Reset mid-operation: the state returns to IDLE on the next edge, regardless of state.

## Timing
- Reset values (cycle after sys_rst is sampled high): grant=0, busy=0, all LEDs = ~RGB_LOGIC_LEVEL, pwm_cnt=0, timers=0, state IDLE.
- Latency:
  - req rising in IDLE → grant/busy high 1 cycle later.
  - grant → rgb pads follow 1 cycle later (pads registered).
  - req drop by owner → grant updated 1 cycle later; pads 1 cycle after that.
- Preemption is possible at the earliest on the cycle the state is OWNED, i.e. MIN_HOLD_MS ms after the grant edge.
- grant is always one-hot or zero; it never glitches between states.

## Test plan
Use CLK_FREQUENCY=1000 (1 cycle/ms), N_REQ=4, MIN_HOLD_MS=4, BLINK_PERIOD_MS=4, PWM_BITS=2, RGB_LOGIC_LEVEL=0.
- Reset: assert sys_rst with req=4'b1111 → grant=0, busy=0, pads=3'b111 after one edge; after release, grant=4'b0001 one cycle later.
- Priority and hold: req[2]=1 (color 3'b010, brightness=3) → grant=4'b0100, g pad low 75% of cycles. Raise req[0] at 1 cycle after grant → grant stays 4'b0100 until 4 cycles after grant, then 4'b0001 on the next cycle.
- Release: owner 1 drops req while req[3] is high → grant=4'b1000 next cycle with no zero-grant gap. Drop req[3] → grant=0, pads=3'b111 two cycles later.
- No lower-priority preemption: owner 1 in OWNED, raise req[2] and req[3] → grant stays 4'b0010 indefinitely.
- Blink and PWM: owner with req_blink=1, color 3'b111, brightness=0 → all pads high always. With brightness=3, pads show a 2-cycle on / 2-cycle off envelope with PWM gaps inside; the phase is ON on the first cycle after handover.
- Reset mid-hold: sys_rst asserted 2 cycles into HOLD → grant=0 next cycle; after release, a new grant gets a full 4-cycle hold.
